// File: rtl/bure_stage_id_if.sv
// Decode-to-execute bundle: one-cycle decode_valid pulse plus decoded operands.
// Latency: none (wires only).
// Backpressure: none; execute always accepts.
interface bure_id_interface #(
    parameter int DATA_WIDTH = 32
);
    logic                  decode_valid;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  is_imm_op;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    modport master (
        output decode_valid, funct3, funct7, is_imm_op, imm, rs1_data, rs2_data
    );

    modport slave (
        input decode_valid, funct3, funct7, is_imm_op, imm, rs1_data, rs2_data
    );
endinterface

// File: rtl/bure_stage_id.sv
// RV32I OP/OP-IMM decode with register file, write-back bypass and busy scoreboard.
// Latency: accept at edge N gives decoded fields on if_id during cycle N+1.
// Backpressure: o_instr_ready drops while a source has a pending write; no downstream stall.
module bure_stage_id #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_instr_valid,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    output logic                   o_instr_ready,
    input  logic                   i_wb_valid,
    input  logic [4:0]             i_wb_rd,
    input  logic [DATA_WIDTH-1:0]  i_wb_data,
    output logic [4:0]             o_rd,
    output logic                   o_illegal,
    bure_id_interface.master       if_id
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    instr_t                ins;
    logic [DATA_WIDTH-1:0] regs [32];
    logic [31:0]           busy;
    logic [31:0]           busy_nxt;

    logic                  is_op;
    logic                  is_opimm;
    logic                  legal;
    logic                  accept;
    logic                  hazard;
    logic                  blk_rs1;
    logic                  blk_rs2;
    logic                  is_shift;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] imm_ext;

    assign ins      = instr_t'(i_instr[31:0]);
    assign is_op    = (ins.opcode == OPC_OP);
    assign is_opimm = (ins.opcode == OPC_OPIMM);
    assign legal    = is_op || is_opimm;
    assign is_shift = (ins.funct3 == 3'b001) || (ins.funct3 == 3'b101);
    assign imm_ext  = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:20]};

    // A write-back arriving this cycle unblocks its consumer immediately via the bypass.
    assign blk_rs1 = (ins.rs1 != 5'd0) && busy[ins.rs1] &&
                     !(i_wb_valid && i_wb_rd == ins.rs1);
    assign blk_rs2 = (ins.rs2 != 5'd0) && busy[ins.rs2] &&
                     !(i_wb_valid && i_wb_rd == ins.rs2);
    assign hazard        = blk_rs1 || (is_op && blk_rs2);
    assign o_instr_ready = !hazard;
    assign accept        = i_instr_valid && o_instr_ready;

    assign rs1_val = (ins.rs1 == 5'd0)                      ? '0        :
                     (i_wb_valid && i_wb_rd == ins.rs1)     ? i_wb_data :
                                                              regs[ins.rs1];
    assign rs2_val = (ins.rs2 == 5'd0)                      ? '0        :
                     (i_wb_valid && i_wb_rd == ins.rs2)     ? i_wb_data :
                                                              regs[ins.rs2];

    // Set after clear so a newer pending write keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (i_wb_valid) begin
            busy_nxt[i_wb_rd] = 1'b0;
        end
        if (accept && legal && ins.rd != 5'd0) begin
            busy_nxt[ins.rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            busy <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            busy <= busy_nxt;
            if (i_wb_valid && i_wb_rd != 5'd0) begin
                regs[i_wb_rd] <= i_wb_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            if_id.decode_valid <= 1'b0;
            if_id.funct3       <= '0;
            if_id.funct7       <= '0;
            if_id.is_imm_op    <= 1'b0;
            if_id.imm          <= '0;
            if_id.rs1_data     <= '0;
            if_id.rs2_data     <= '0;
            o_rd               <= '0;
            o_illegal          <= 1'b0;
        end else begin
            if_id.decode_valid <= accept && legal;
            o_illegal          <= accept && !legal;
            if (accept && legal) begin
                if_id.funct3    <= ins.funct3;
                if_id.funct7    <= (is_op || is_shift) ? ins.funct7 : 7'd0;
                if_id.is_imm_op <= is_opimm;
                if_id.imm       <= is_opimm ? imm_ext : '0;
                if_id.rs1_data  <= rs1_val;
                if_id.rs2_data  <= is_op ? rs2_val : '0;
                o_rd            <= ins.rd;
            end
        end
    end
endmodule

// File: tb/tb_bure_stage_id.sv
// Bench for bure_stage_id: directed vector table plus randomized run against a reference model.
module tb_bure_stage_id;
    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_instr_valid = 1'b0;
    logic [31:0] i_instr = '0;
    logic        o_instr_ready;
    logic        i_wb_valid = 1'b0;
    logic [4:0]  i_wb_rd = '0;
    logic [31:0] i_wb_data = '0;
    logic [4:0]  o_rd;
    logic        o_illegal;

    bure_id_interface #(.DATA_WIDTH(32)) id_if ();

    bure_stage_id #(.DATA_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_instr_valid (i_instr_valid),
        .i_instr       (i_instr),
        .o_instr_ready (o_instr_ready),
        .i_wb_valid    (i_wb_valid),
        .i_wb_rd       (i_wb_rd),
        .i_wb_data     (i_wb_data),
        .o_rd          (o_rd),
        .o_illegal     (o_illegal),
        .if_id         (id_if)
    );

    initial forever #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int cur_row = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, cur_row, act, exp);
        end
    endtask

    // Reference model: architectural registers, pending-write flags, expected outputs.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic        m_dv, m_ill, m_immop;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [31:0] m_imm, m_rs1, m_rs2;

    function automatic logic [31:0] m_src(input logic [4:0] r, input logic wbv,
                                          input logic [4:0] wbrd, input logic [31:0] wbd);
        if (r == 0) return 32'd0;
        if (wbv && wbrd == r) return wbd;
        return m_regs[r];
    endfunction

    function automatic bit m_blocked(input logic [4:0] r, input logic wbv, input logic [4:0] wbrd);
        return (r != 0) && m_busy[r] && !(wbv && wbrd == r);
    endfunction

    function automatic logic m_ready(input logic [31:0] ins, input logic wbv, input logic [4:0] wbrd);
        logic [31:0] w;
        w = ins;
        if (m_blocked(w[19:15], wbv, wbrd)) return 1'b0;
        if (w[6:0] == 7'h33 && m_blocked(w[24:20], wbv, wbrd)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_update(input logic rstn, input logic acc, input logic [31:0] ins,
                            input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd);
        logic [6:0] opc;
        logic       lg;
        opc = ins[6:0];
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
            {m_dv, m_ill, m_immop} = '0;
            m_rd = '0; m_f3 = '0; m_f7 = '0;
            m_imm = '0; m_rs1 = '0; m_rs2 = '0;
            return;
        end
        lg    = (opc == 7'h33) || (opc == 7'h13);
        m_dv  = acc && lg;
        m_ill = acc && !lg;
        if (m_dv) begin
            m_f3    = ins[14:12];
            m_immop = (opc == 7'h13);
            if (opc == 7'h33 || m_f3 == 3'd1 || m_f3 == 3'd5) m_f7 = ins[31:25];
            else m_f7 = 7'd0;
            m_imm = m_immop ? {{20{ins[31]}}, ins[31:20]} : 32'd0;
            m_rs1 = m_src(ins[19:15], wbv, wbrd, wbd);
            m_rs2 = m_immop ? 32'd0 : m_src(ins[24:20], wbv, wbrd, wbd);
            m_rd  = ins[11:7];
        end
        if (wbv) begin
            m_busy[wbrd] = 1'b0;
            if (wbrd != 0) m_regs[wbrd] = wbd;
        end
        if (m_dv && ins[11:7] != 0) m_busy[ins[11:7]] = 1'b1;
    endtask

    // One clock: drive, sample ready before the edge, advance model, settle after the edge.
    task automatic apply(input logic rstn, input logic vld, input logic [31:0] ins,
                         input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                         output logic rdy, output logic mrdy);
        i_rstn = rstn; i_instr_valid = vld; i_instr = ins;
        i_wb_valid = wbv; i_wb_rd = wbrd; i_wb_data = wbd;
        #1;
        rdy  = o_instr_ready;
        mrdy = m_ready(ins, wbv, wbrd);
        @(posedge i_clk);
        m_update(rstn, vld && mrdy, ins, wbv, wbrd, wbd);
        #1;
    endtask

    task automatic chk_fields(input logic [4:0] erd, input logic [2:0] ef3, input logic [6:0] ef7,
                              input logic eimmop, input logic [31:0] eimm, input logic [31:0] ers1,
                              input logic [31:0] ers2);
        chk("o_rd",      {27'd0, o_rd},            {27'd0, erd});
        chk("funct3",    {29'd0, id_if.funct3},    {29'd0, ef3});
        chk("funct7",    {25'd0, id_if.funct7},    {25'd0, ef7});
        chk("is_imm_op", {31'd0, id_if.is_imm_op}, {31'd0, eimmop});
        chk("imm",       id_if.imm,                eimm);
        chk("rs1_data",  id_if.rs1_data,           ers1);
        chk("rs2_data",  id_if.rs2_data,           ers2);
    endtask

    typedef struct {
        logic        rstn, vld;
        logic [31:0] instr;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        erdy, edv, eill, chkf;
        logic [4:0]  erd;
        logic [2:0]  ef3;
        logic [6:0]  ef7;
        logic        eimmop;
        logic [31:0] eimm, ers1, ers2;
    } vec_t;

    function automatic vec_t mk(input logic rstn, vld, input logic [31:0] instr,
                                input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                                input logic erdy, edv, eill, chkf, input logic [4:0] erd,
                                input logic [2:0] ef3, input logic [6:0] ef7, input logic eimmop,
                                input logic [31:0] eimm, ers1, ers2);
        vec_t v;
        v.rstn = rstn; v.vld = vld; v.instr = instr; v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
        v.erdy = erdy; v.edv = edv; v.eill = eill; v.chkf = chkf; v.erd = erd;
        v.ef3 = ef3; v.ef7 = ef7; v.eimmop = eimmop; v.eimm = eimm; v.ers1 = ers1; v.ers2 = ers2;
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 4)      w[6:0] = 7'h33;
        else if (k < 8) w[6:0] = 7'h13;
        else begin
            case ($urandom_range(0, 3))
                0:       w[6:0] = 7'h03;
                1:       w[6:0] = 7'h23;
                2:       w[6:0] = 7'h63;
                default: w[6:0] = 7'h37;
            endcase
        end
        if (w[6:0] == 7'h33 && $urandom_range(0, 1) == 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    vec_t tbl[$];

    initial begin
        logic        rdy, mrdy, hold, rv, wv, rst;
        logic [31:0] cur, wd;
        logic [4:0]  wr;

        //          rstn vld instr         wbv rd  data          rdy dv ill chk rd  f3 f7     io imm           rs1           rs2
        tbl.push_back(mk(0, 1, 32'hFFF08113, 1, 3, 32'h55,        1, 0, 0, 1, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(0, 1, 32'hFFF08113, 1, 3, 32'h55,        1, 0, 0, 1, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 0, 0,             1, 0, 0, 1, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00018513, 0, 0, 0,             1, 1, 0, 1, 10, 0, 0,     1, 0,            0,            0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h10,        1, 0, 0, 0, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'hFFF08113, 0, 0, 0,             1, 1, 0, 1, 2,  0, 0,     1, 32'hFFFFFFFF, 32'h10,       0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 2, 32'h3,         1, 0, 0, 0, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h402081B3, 0, 0, 0,             1, 1, 0, 1, 3,  0, 7'h20, 0, 0,            32'h10,       32'h3));
        tbl.push_back(mk(1, 1, 32'h4030D213, 0, 0, 0,             1, 1, 0, 1, 4,  5, 7'h20, 1, 32'h403,      32'h10,       0));
        tbl.push_back(mk(1, 1, 32'h00700293, 0, 0, 0,             1, 1, 0, 1, 5,  0, 0,     1, 32'h7,        0,            0));
        tbl.push_back(mk(1, 1, 32'h00528333, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00528333, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00528333, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00528333, 1, 5, 32'h7,         1, 1, 0, 1, 6,  0, 0,     0, 0,            32'h7,        32'h7));
        tbl.push_back(mk(1, 1, 32'h00500393, 0, 0, 0,             1, 1, 0, 1, 7,  0, 0,     1, 32'h5,        0,            0));
        tbl.push_back(mk(1, 1, 32'h00138393, 1, 7, 32'h77,        1, 1, 0, 1, 7,  0, 0,     1, 32'h1,        32'h77,       0));
        tbl.push_back(mk(1, 1, 32'h00038433, 0, 0, 0,             0, 0, 0, 0, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00038433, 1, 7, 32'h78,        1, 1, 0, 1, 8,  0, 0,     0, 0,            32'h78,       0));
        tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'hDEAD,      1, 0, 0, 0, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00000493, 0, 0, 0,             1, 1, 0, 1, 9,  0, 0,     1, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00000003, 0, 0, 0,             1, 0, 1, 1, 9,  0, 0,     1, 0,            0,            0));
        tbl.push_back(mk(1, 0, 32'h0,        0, 0, 0,             1, 0, 0, 1, 9,  0, 0,     1, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00000583, 0, 0, 0,             1, 0, 1, 0, 0,  0, 0,     0, 0,            0,            0));
        tbl.push_back(mk(1, 1, 32'h00058613, 0, 0, 0,             1, 1, 0, 1, 12, 0, 0,     1, 0,            0,            0));

        foreach (tbl[i]) begin
            cur_row = i;
            apply(tbl[i].rstn, tbl[i].vld, tbl[i].instr, tbl[i].wbv, tbl[i].wbrd, tbl[i].wbd, rdy, mrdy);
            if (tbl[i].rstn) chk("ready", {31'd0, rdy}, {31'd0, tbl[i].erdy});
            chk("decode_valid", {31'd0, id_if.decode_valid}, {31'd0, tbl[i].edv});
            chk("illegal",      {31'd0, o_illegal},          {31'd0, tbl[i].eill});
            if (tbl[i].chkf)
                chk_fields(tbl[i].erd, tbl[i].ef3, tbl[i].ef7, tbl[i].eimmop,
                           tbl[i].eimm, tbl[i].ers1, tbl[i].ers2);
        end

        // Randomized run: fetch holds a stalled word; occasional reset lands mid-stall.
        hold = 1'b0;
        cur  = '0;
        for (int n = 0; n < 3000; n++) begin
            cur_row = 1000 + n;
            rst = ($urandom_range(0, 99) == 0);
            if (!hold) begin
                rv  = ($urandom_range(0, 3) != 0);
                cur = rand_instr();
            end
            wv = ($urandom_range(0, 2) == 0);
            wr = 5'($urandom_range(0, 7));
            wd = $urandom;
            apply(!rst, rv, cur, wv, wr, wd, rdy, mrdy);
            if (!rst) chk("rand_ready", {31'd0, rdy}, {31'd0, mrdy});
            chk("rand_decode_valid", {31'd0, id_if.decode_valid}, {31'd0, m_dv});
            chk("rand_illegal",      {31'd0, o_illegal},          {31'd0, m_ill});
            chk_fields(m_rd, m_f3, m_f7, m_immop, m_imm, m_rs1, m_rs2);
            hold = !rst && rv && !mrdy;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bure_stage_id.md
# bure_stage_id

Instruction decode stage of the Bure pipeline: the producer side of `bure_id_interface`, driving the execute stage through the `master` modport. It accepts one fetched RV32I word per cycle and decodes OP and OP-IMM ALU instructions. It holds the 31×32 integer register file, with write-back-to-read bypass, and keeps a per-register busy scoreboard. An instruction that reads a register with a pending write is stalled until that write-back arrives.

## Interface
- `DATA_WIDTH`, 32, register and operand width.
- `INSTR_WIDTH`, 32, instruction word width.
- `i_clk`  in  1  single clock; everything samples on rising edge.
- `i_rstn`  in  1  reset, synchronous, active-low.
- `i_instr_valid`  in  1  fetch presents an instruction.
- `i_instr`  in  INSTR_WIDTH  instruction word.
- `o_instr_ready`  out  1  decode accepts the instruction this cycle.
- `i_wb_valid`  in  1  write-back strobe.
- `i_wb_rd`  in  5  write-back destination.
- `i_wb_data`  in  DATA_WIDTH  write-back value.
- `o_rd`  out  5  destination register of the instruction on `if_id`.
- `o_illegal`  out  1  one-cycle pulse: unsupported opcode was consumed.
- `if_id`  `bure_id_interface.master`. Drives `decode_valid`, `funct3`, `funct7`, `is_imm_op`, `imm`, `rs1_data`, `rs2_data`.

## Operation
- **Accept.** Handshake fires when `i_instr_valid && o_instr_ready`.
- **Ready.** `o_instr_ready` = !hazard. hazard = (rs1 != 0 && busy[rs1] && !wb_clears(rs1)) || (rs2_used && rs2 != 0 && busy[rs2] && !wb_clears(rs2)).
  - wb_clears(r) = `i_wb_valid && i_wb_rd == r`.
  - rs2_used only for OP.
- **Fields.** opcode = instr[6:0]; rd = [11:7]; funct3 = [14:12]; rs1 = [19:15]; rs2 = [24:20].
- **OP (0110011).**
  - is_imm_op = 0; funct7 = instr[31:25]; imm = 0.
  - rs2_data = register file rs2.
- **OP-IMM (0010011).**
  - is_imm_op = 1; imm = sign-extend instr[31:20] to DATA_WIDTH.
  - funct7 = instr[31:25] when funct3 ∈ {001, 101} (shifts), else 0.
  - rs2_data = 0.
- **Any other opcode.**
  - Instruction is consumed; next cycle `decode_valid` = 0 and `o_illegal` = 1.
  - No scoreboard update.
- **Register read.**
  - x0 always reads 0.
  - If `i_wb_valid` and `i_wb_rd` equals a nonzero source in the same cycle, the read returns `i_wb_data` (bypass).
- **Register write.** On `i_wb_valid && i_wb_rd != 0`, the register file is written at the edge. A write-back to x0 is ignored.
- **Scoreboard.**
  - On accept of a legal instruction with rd != 0, busy[rd] is set.
  - On `i_wb_valid`, busy[i_wb_rd] is cleared.
  - Same register set and cleared in the same cycle: set wins (the newer write is pending).
  - busy[0] is constantly 0.
- **No accept.** If no handshake fires, the next cycle has `decode_valid` = 0 and `o_illegal` = 0. All data outputs hold their last values.

## Timing
- **Reset.** While `i_rstn` = 0 at an edge, after that edge:
  - `decode_valid`, `o_illegal`, `funct3`, `funct7`, `is_imm_op`, `imm`, `rs1_data`, `rs2_data`, `o_rd` are all 0.
  - All busy bits are 0 and all registers are 0.
  - Write-backs during reset are discarded.
  - Reset mid-stall drops the pending instruction and all scoreboard state.
- **`o_instr_ready`** is combinational from the scoreboard, instr and wb inputs. It may be 1 while `i_instr_valid` = 0.
- **Latency.** Accept at edge N gives `if_id` fields and `decode_valid` = 1 during cycle N+1. `decode_valid` is a one-cycle pulse per accepted legal instruction.
- **Throughput.** One instruction per cycle while there is no hazard. Back-to-back independent instructions produce continuous `decode_valid`.
- **Stall.** While stalled, fetch must hold `i_instr`. The instruction is accepted in the same cycle its blocking write-back arrives (via bypass), so the stall is zero cycles past the write-back.
- **Downstream.** There is no backpressure from execute; execute always accepts.

## Test plan
- **Reset.**
  - Stimulus: hold `i_rstn` low 2 cycles with `i_instr_valid` = 1 and `i_wb_valid` = 1.
  - Required: all outputs 0 and `decode_valid` never high; a later read of that wb_rd returns 0.
- **OP-IMM decode.**
  - Stimulus: write x1 = 0x0000_0010, then issue `addi x2,x1,-1` (0xFFF08113).
  - Required: next cycle `decode_valid` = 1, is_imm_op = 1, imm = 0xFFFF_FFFF, rs1_data = 0x10, funct3 = 0, funct7 = 0, o_rd = 2.
- **OP and shift decode.**
  - Stimulus: issue `sub x3,x1,x2` (0x402081B3), then `srai x4,x1,3` (0x4030D213).
  - Required: funct7 = 0x20 on both; rs2_data equals x2 for the SUB; rs2_data = 0 for the SRAI.
- **RAW stall.**
  - Stimulus: issue `addi x5,x0,7`, then `add x6,x5,x5` immediately, with no write-back for 3 cycles, then `i_wb_valid`/rd = 5/data = 7.
  - Required: `o_instr_ready` = 0 for those 3 cycles; accept in the wb cycle; rs1_data = rs2_data = 7.
- **Set/clear collision.**
  - Stimulus: x7 busy; in one cycle, write back x7 and accept `addi x7,x7,1`.
  - Required: rs1_data = wb value; busy[7] remains 1; the following `add x8,x7,x0` stalls.
- **x0 and illegal.**
  - Stimulus: write back x0 = 0xDEAD, issue `addi x9,x0,0`, then issue 0x0000_0003 (load).
  - Required: rs1_data = 0; then `o_illegal` pulses 1 for one cycle with `decode_valid` = 0; no busy bit set.
